// File: rtl/mac_pkg.sv
// Shared widths, operand/product records and a ring-index helper for the MAC multiplier path.
package mac_pkg;

    localparam int MAC_EXP_W   = 4;
    localparam int MAC_MANT_W  = 9;
    localparam int MAC_OEXP_W  = 5;
    localparam int MAC_OMANT_W = 18;

    typedef struct packed {
        logic                  sign;
        logic [MAC_EXP_W-1:0]  exp;
        logic [MAC_MANT_W-1:0] mant;
    } mac_operand_t;

    typedef struct packed {
        logic                   sign;
        logic [MAC_OEXP_W-1:0]  exp;
        logic [MAC_OMANT_W-1:0] mant;
    } mac_product_t;

    // (base + off) mod n, valid for base < n and off <= n.
    function automatic int rr_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/mac_multiplier_mid.sv
// Combinational sign/exponent/mantissa multiplier: no bias, rounding or normalisation.
module mac_multiplier_mid
    import mac_pkg::*;
(
    input  logic                   i_a_sign,
    input  logic [MAC_EXP_W-1:0]   i_a_exp,
    input  logic [MAC_MANT_W-1:0]  i_a_mant,
    input  logic                   i_b_sign,
    input  logic [MAC_EXP_W-1:0]   i_b_exp,
    input  logic [MAC_MANT_W-1:0]  i_b_mant,
    output logic                   o_sign,
    output logic [MAC_OEXP_W-1:0]  o_exp,
    output logic [MAC_OMANT_W-1:0] o_mant
);

    logic [MAC_OEXP_W-1:0]  w_a_exp_ext;
    logic [MAC_OEXP_W-1:0]  w_b_exp_ext;
    logic [MAC_OMANT_W-1:0] w_a_mant_ext;
    logic [MAC_OMANT_W-1:0] w_b_mant_ext;

    assign w_a_exp_ext  = MAC_OEXP_W'(i_a_exp);
    assign w_b_exp_ext  = MAC_OEXP_W'(i_b_exp);
    assign w_a_mant_ext = MAC_OMANT_W'(i_a_mant);
    assign w_b_mant_ext = MAC_OMANT_W'(i_b_mant);

    // Output widths are sized so neither the sum nor the product can overflow.
    assign o_sign = i_a_sign ^ i_b_sign;
    assign o_exp  = w_a_exp_ext + w_b_exp_ext;
    assign o_mant = w_a_mant_ext * w_b_mant_ext;

endmodule

// File: rtl/mac_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins, when enabled.
module mac_rr_arbiter
    import mac_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id
);

    logic w_found;

    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (i_en && !w_found && i_req[k] && (k == rr_add(int'(i_ptr), i, NUM_REQ))) begin
                    o_grant[k] = 1'b1;
                    o_grant_id = ID_W'(k);
                    w_found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mac_mult_arbiter.sv
// Shares one multiplier between NUM_REQ requesters: round-robin grant, operand stage,
// product stage, tagged valid/ready result port.
module mac_mult_arbiter
    import mac_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ-1:0]            i_a_sign,
    input  logic [NUM_REQ*MAC_EXP_W-1:0]  i_a_exp,
    input  logic [NUM_REQ*MAC_MANT_W-1:0] i_a_mant,
    input  logic [NUM_REQ-1:0]            i_b_sign,
    input  logic [NUM_REQ*MAC_EXP_W-1:0]  i_b_exp,
    input  logic [NUM_REQ*MAC_MANT_W-1:0] i_b_mant,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [ID_W-1:0]               o_id,
    output logic                          o_sign,
    output logic [MAC_OEXP_W-1:0]         o_exp,
    output logic [MAC_OMANT_W-1:0]        o_mant,
    output logic                          o_idle
);

    logic [ID_W-1:0] r_ptr;
    logic            r_s1_valid;
    logic [ID_W-1:0] r_s1_id;
    mac_operand_t    r_s1_a;
    mac_operand_t    r_s1_b;
    logic            r_s2_valid;
    logic [ID_W-1:0] r_s2_id;
    mac_product_t    r_s2_prod;

    logic               w_s2_adv;
    logic               w_s1_adv;
    logic               w_arb_en;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_xfer;
    mac_operand_t       w_op_a;
    mac_operand_t       w_op_b;
    mac_product_t       w_prod;

    assign w_s2_adv = !r_s2_valid || i_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    // Keep ready low during reset so no requester sees a handshake that is then dropped.
    assign w_arb_en = w_s1_adv && rstn;

    mac_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req      (i_req_valid),
        .i_ptr      (r_ptr),
        .i_en       (w_arb_en),
        .o_grant    (w_grant),
        .o_grant_id (w_gnt_id)
    );

    assign o_req_ready = w_grant;
    assign w_xfer      = |w_grant;

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_id == ID_W'(k)) begin
                w_op_a.sign = i_a_sign[k];
                w_op_a.exp  = i_a_exp[k*MAC_EXP_W +: MAC_EXP_W];
                w_op_a.mant = i_a_mant[k*MAC_MANT_W +: MAC_MANT_W];
                w_op_b.sign = i_b_sign[k];
                w_op_b.exp  = i_b_exp[k*MAC_EXP_W +: MAC_EXP_W];
                w_op_b.mant = i_b_mant[k*MAC_MANT_W +: MAC_MANT_W];
            end
        end
    end

    mac_multiplier_mid u_mul (
        .i_a_sign (r_s1_a.sign),
        .i_a_exp  (r_s1_a.exp),
        .i_a_mant (r_s1_a.mant),
        .i_b_sign (r_s1_b.sign),
        .i_b_exp  (r_s1_b.exp),
        .i_b_mant (r_s1_b.mant),
        .o_sign   (w_prod.sign),
        .o_exp    (w_prod.exp),
        .o_mant   (w_prod.mant)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_prod  <= '0;
        end else begin
            if (w_xfer) begin
                r_ptr <= ID_W'(rr_add(int'(w_gnt_id), 1, NUM_REQ));
            end
            // An idle grant slot still loads, clearing s1_valid to form a bubble.
            if (w_s1_adv) begin
                r_s1_valid <= w_xfer;
                r_s1_id    <= w_gnt_id;
                r_s1_a     <= w_op_a;
                r_s1_b     <= w_op_b;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                r_s2_id    <= r_s1_id;
                r_s2_prod  <= w_prod;
            end
        end
    end

    assign o_valid = r_s2_valid;
    assign o_id    = r_s2_id;
    assign o_sign  = r_s2_prod.sign;
    assign o_exp   = r_s2_prod.exp;
    assign o_mant  = r_s2_prod.mant;
    assign o_idle  = !r_s1_valid && !r_s2_valid && !(|i_req_valid);

endmodule

// File: tb/tb_mac_mult_arbiter.sv
// Directed bench for mac_mult_arbiter: product vectors, round-robin order, backpressure, reset.
module tb_mac_mult_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NUM_REQ-1:0]  req_valid;
    logic [NUM_REQ-1:0]  req_ready;
    logic [NUM_REQ-1:0]  a_sign;
    logic [NUM_REQ*4-1:0] a_exp;
    logic [NUM_REQ*9-1:0] a_mant;
    logic [NUM_REQ-1:0]  b_sign;
    logic [NUM_REQ*4-1:0] b_exp;
    logic [NUM_REQ*9-1:0] b_mant;
    logic                o_valid;
    logic                i_ready;
    logic [ID_W-1:0]     o_id;
    logic                o_sign;
    logic [4:0]          o_exp;
    logic [17:0]         o_mant;
    logic                o_idle;

    int n_checks = 0;
    int n_errors = 0;
    int out_id_q[$];
    int out_mant_q[$];

    always #5 clk = ~clk;

    mac_mult_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_a_sign    (a_sign),
        .i_a_exp     (a_exp),
        .i_a_mant    (a_mant),
        .i_b_sign    (b_sign),
        .i_b_exp     (b_exp),
        .i_b_mant    (b_mant),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_id        (o_id),
        .o_sign      (o_sign),
        .o_exp       (o_exp),
        .o_mant      (o_mant),
        .o_idle      (o_idle)
    );

    // Record every output beat that will complete at the coming rising edge.
    always @(negedge clk) begin
        if (rstn && o_valid && i_ready) begin
            out_id_q.push_back(int'(o_id));
            out_mant_q.push_back(int'(o_mant));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         req;
        logic       as;
        logic [3:0] ae;
        logic [8:0] am;
        logic       bs;
        logic [3:0] be;
        logic [8:0] bm;
        logic       es;
        logic [4:0] ee;
        logic [17:0] em;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req_v);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1;
        out_id_q.delete();
        out_mant_q.delete();
    endtask

    // Requester k: a=(0,k,k+1), b=(0,1,2) -> exp k+1, mant 2*(k+1).
    task automatic set_tagged_ops();
        for (int k = 0; k < NUM_REQ; k++) begin
            a_sign[k]       = 1'b0;
            a_exp[k*4 +: 4] = 4'(k);
            a_mant[k*9 +: 9] = 9'(k + 1);
            b_sign[k]       = 1'b0;
            b_exp[k*4 +: 4] = 4'd1;
            b_mant[k*9 +: 9] = 9'd2;
        end
    endtask

    task automatic check_outputs(input string name, input int exp_ids[]);
        chk({name, "_count"}, out_id_q.size(), exp_ids.size());
        for (int i = 0; i < exp_ids.size(); i++) begin
            if (i < out_id_q.size()) begin
                chk($sformatf("%s_id%0d", name, i), out_id_q[i], exp_ids[i]);
                chk($sformatf("%s_mant%0d", name, i), out_mant_q[i], 2 * (exp_ids[i] + 1));
            end
        end
    endtask

    initial begin
        logic [3:0] onehot;
        int rdy_bp[9];
        int ids_rr[];
        int ids_sp[];
        int ids_bp[];

        vecs[0] = '{0, 1'b0, 4'd3,  9'h100, 1'b1, 4'd2,  9'h180, 1'b1, 5'd5,  18'h18000};
        vecs[1] = '{1, 1'b1, 4'd15, 9'h1FF, 1'b1, 4'd15, 9'h1FF, 1'b0, 5'd30, 18'h3FC01};
        vecs[2] = '{2, 1'b0, 4'd0,  9'h000, 1'b0, 4'd0,  9'h000, 1'b0, 5'd0,  18'h00000};
        vecs[3] = '{3, 1'b1, 4'd7,  9'h003, 1'b0, 4'd8,  9'h005, 1'b1, 5'd15, 18'h0000F};
        vecs[4] = '{0, 1'b0, 4'd15, 9'h1FF, 1'b1, 4'd0,  9'h001, 1'b1, 5'd15, 18'h001FF};
        vecs[5] = '{1, 1'b1, 4'd1,  9'h0AA, 1'b1, 4'd2,  9'h002, 1'b0, 5'd3,  18'h00154};
        vecs[6] = '{2, 1'b0, 4'd9,  9'h100, 1'b0, 4'd6,  9'h100, 1'b0, 5'd15, 18'h10000};

        rstn = 1'b0;
        req_valid = '0;
        i_ready = 1'b1;
        a_sign = '0; a_exp = '0; a_mant = '0;
        b_sign = '0; b_exp = '0; b_mant = '0;

        // Reset state
        sample();
        chk("ready_in_reset", req_ready, 4'b0000);
        next_cycle();
        next_cycle();
        rstn = 1'b1;
        sample();
        chk("rst_valid", o_valid, 0);
        chk("rst_id", o_id, 0);
        chk("rst_sign", o_sign, 0);
        chk("rst_exp", o_exp, 0);
        chk("rst_mant", o_mant, 0);
        chk("rst_idle", o_idle, 1);
        next_cycle();

        // Single-product vectors
        for (int v = 0; v < 7; v++) begin
            a_sign = '0; a_exp = '0; a_mant = '0;
            b_sign = '0; b_exp = '0; b_mant = '0;
            a_sign[vecs[v].req]          = vecs[v].as;
            a_exp[vecs[v].req*4 +: 4]    = vecs[v].ae;
            a_mant[vecs[v].req*9 +: 9]   = vecs[v].am;
            b_sign[vecs[v].req]          = vecs[v].bs;
            b_exp[vecs[v].req*4 +: 4]    = vecs[v].be;
            b_mant[vecs[v].req*9 +: 9]   = vecs[v].bm;
            onehot = 4'b0001 << vecs[v].req;
            req_valid = onehot;
            sample();
            chk($sformatf("v%0d_ready", v), req_ready, onehot);
            next_cycle();
            req_valid = '0;
            sample();
            chk($sformatf("v%0d_early_valid", v), o_valid, 0);
            next_cycle();
            sample();
            chk($sformatf("v%0d_valid", v), o_valid, 1);
            chk($sformatf("v%0d_id", v), o_id, vecs[v].req);
            chk($sformatf("v%0d_sign", v), o_sign, vecs[v].es);
            chk($sformatf("v%0d_exp", v), o_exp, vecs[v].ee);
            chk($sformatf("v%0d_mant", v), o_mant, vecs[v].em);
            next_cycle();
        end
        sample();
        chk("idle_after_vectors", o_idle, 1);
        next_cycle();

        // Round-robin: all requesters valid for 8 cycles
        set_tagged_ops();
        pulse_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            sample();
            onehot = 4'b0001 << (c % 4);
            chk($sformatf("rr_ready%0d", c), req_ready, onehot);
            next_cycle();
        end
        req_valid = '0;
        for (int c = 0; c < 3; c++) next_cycle();
        ids_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_outputs("rr", ids_rr);

        // Sparse: only req2 and req3
        pulse_reset();
        req_valid = 4'b1100;
        for (int c = 0; c < 4; c++) begin
            sample();
            onehot = (c % 2 == 0) ? 4'b0100 : 4'b1000;
            chk($sformatf("sp_ready%0d", c), req_ready, onehot);
            next_cycle();
        end
        req_valid = '0;
        for (int c = 0; c < 3; c++) next_cycle();
        ids_sp = '{2, 3, 2, 3};
        check_outputs("sp", ids_sp);

        // Backpressure: i_ready low for the first 4 cycles
        pulse_reset();
        rdy_bp = '{1, 2, 0, 0, 4, 8, 1, 2, 4};
        req_valid = 4'hF;
        i_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (c == 4) i_ready = 1'b1;
            sample();
            chk($sformatf("bp_ready%0d", c), req_ready, rdy_bp[c]);
            if (c == 2 || c == 3) begin
                chk($sformatf("bp_hold_valid%0d", c), o_valid, 1);
                chk($sformatf("bp_hold_id%0d", c), o_id, 0);
                chk($sformatf("bp_hold_exp%0d", c), o_exp, 1);
                chk($sformatf("bp_hold_mant%0d", c), o_mant, 2);
            end
            next_cycle();
        end
        req_valid = '0;
        for (int c = 0; c < 4; c++) next_cycle();
        ids_bp = '{0, 1, 2, 3, 0, 1, 2};
        check_outputs("bp", ids_bp);

        // Reset mid-flight with both stages full
        pulse_reset();
        req_valid = 4'hF;
        i_ready = 1'b0;
        next_cycle();
        next_cycle();
        sample();
        chk("mid_full_valid", o_valid, 1);
        rstn = 1'b0;
        sample();
        chk("mid_ready_in_reset", req_ready, 4'b0000);
        next_cycle();
        rstn = 1'b1;
        req_valid = '0;
        sample();
        chk("mid_valid", o_valid, 0);
        chk("mid_id", o_id, 0);
        chk("mid_sign", o_sign, 0);
        chk("mid_exp", o_exp, 0);
        chk("mid_mant", o_mant, 0);
        chk("mid_idle", o_idle, 1);
        next_cycle();
        req_valid = 4'hF;
        i_ready = 1'b1;
        sample();
        chk("mid_first_grant", req_ready, 4'b0001);
        next_cycle();
        req_valid = '0;
        for (int c = 0; c < 3; c++) next_cycle();
        chk("mid_out_count", out_id_q.size(), 1);
        if (out_id_q.size() > 0) chk("mid_out_id", out_id_q[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
